// File: rtl/i2s_stream_packer_if.sv
// AXI-Stream style output bus of the I2S stream packer.
interface i2s_stream_packer_if;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;

  modport master (output m_tdata, output m_tvalid, output m_tlast, input m_tready);
  modport slave  (input m_tdata, input m_tvalid, input m_tlast, output m_tready);
endinterface

// File: rtl/i2s_stream_packer.sv
// Pairs left/right I2S samples into stereo frames, buffers them in a FIFO and
// serialises each frame as two sign-extended 32-bit words with packet framing.
module i2s_stream_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PKT_LEN    = 256
) (
  input  logic                        AMSCK,
  input  logic                        rst_n,
  input  logic [23:0]                 din,
  input  logic                        valid_l,
  input  logic                        valid_r,
  input  logic                        enable,
  input  logic                        clr_flags,
  i2s_stream_packer_if.master         axis,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        sync_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [0:0] WAIT_L = 1'b0;
  localparam logic [0:0] WAIT_R = 1'b1;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
    logic        last;
  } frame_t;

  logic [0:0]    state, state_n;
  logic [23:0]   hold_l, hold_n;
  logic          frame_req, sync_set;

  logic          pend_vld;
  logic [23:0]   pend_l, pend_r;

  frame_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [CW-1:0] pkt_cnt;
  logic          pkt_last;
  logic          phase, phase_n;
  logic          push, pop, hs;
  logic [LW-1:0] level_n;
  frame_t        wr_frame, head;

  logic [31:0]   tdata_q;
  logic          tvalid_q, tlast_q;

  assign axis.m_tdata  = tdata_q;
  assign axis.m_tvalid = tvalid_q;
  assign axis.m_tlast  = tlast_q;

  // Pairing FSM state register
  always_ff @(posedge AMSCK or negedge rst_n) begin
    if (!rst_n) begin
      state  <= WAIT_L;
      hold_l <= '0;
    end else begin
      state  <= state_n;
      hold_l <= hold_n;
    end
  end

  // Pairing FSM next state; disabled capture drops any half-built frame
  always_comb begin
    state_n   = state;
    hold_n    = hold_l;
    frame_req = 1'b0;
    sync_set  = 1'b0;
    if (!enable) begin
      state_n = WAIT_L;
    end else if (valid_l && valid_r) begin
      state_n  = WAIT_L;
      sync_set = 1'b1;
    end else begin
      case (state)
        WAIT_L: begin
          if (valid_l) begin
            hold_n  = din;
            state_n = WAIT_R;
          end
        end
        WAIT_R: begin
          if (valid_r) begin
            frame_req = 1'b1;
            state_n   = WAIT_L;
          end else if (valid_l) begin
            hold_n   = din;
            sync_set = 1'b1;
          end
        end
        default: state_n = WAIT_L;
      endcase
    end
  end

  // Completed frame waits one cycle here before the FIFO push decision
  always_ff @(posedge AMSCK or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_l   <= '0;
      pend_r   <= '0;
    end else begin
      pend_vld <= frame_req;
      if (frame_req) begin
        pend_l <= hold_l;
        pend_r <= din;
      end
    end
  end

  assign push     = pend_vld && (level < LW'(FIFO_DEPTH));
  assign pkt_last = (pkt_cnt == CW'(PKT_LEN - 1));
  assign wr_frame = {pend_l, pend_r, pkt_last};

  // Head of the FIFO after this edge; bypass when the new frame lands in an empty FIFO
  always_comb begin
    hs      = tvalid_q & axis.m_tready;
    pop     = hs & phase;
    phase_n = hs ? ~phase : phase;
    rd_n    = rd_ptr + AW'(pop);
    level_n = level + LW'(push) - LW'(pop);
    head    = (push && (rd_n == wr_ptr)) ? wr_frame : mem[rd_n];
  end

  always_ff @(posedge AMSCK) begin
    if (push) mem[wr_ptr] <= wr_frame;
  end

  // FIFO control and registered serialiser outputs
  always_ff @(posedge AMSCK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pkt_cnt  <= '0;
      level    <= '0;
      phase    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        pkt_cnt <= pkt_last ? '0 : pkt_cnt + CW'(1);
      end
      rd_ptr   <= rd_n;
      level    <= level_n;
      phase    <= phase_n;
      tvalid_q <= (level_n != '0);
      if (level_n == '0)
        tdata_q <= '0;
      else if (phase_n)
        tdata_q <= {{8{head.right[23]}}, head.right};
      else
        tdata_q <= {{8{head.left[23]}}, head.left};
      tlast_q  <= (level_n != '0) & phase_n & head.last;
    end
  end

  // Sticky error flags; a new event wins over a simultaneous clear
  always_ff @(posedge AMSCK or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      overflow <= (pend_vld & ~push) | (overflow & ~clr_flags);
      sync_err <= sync_set | (sync_err & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_i2s_stream_packer.sv
// Scoreboard bench for i2s_stream_packer (FIFO_DEPTH=4, PKT_LEN=4).
module tb_i2s_stream_packer;

  logic        AMSCK = 1'b0;
  logic        rst_n;
  logic [23:0] din;
  logic        valid_l, valid_r, enable, clr_flags;
  logic [2:0]  level;
  logic        overflow, sync_err;

  i2s_stream_packer_if axis ();

  i2s_stream_packer #(.FIFO_DEPTH(4), .PKT_LEN(4)) dut (
    .AMSCK     (AMSCK),
    .rst_n     (rst_n),
    .din       (din),
    .valid_l   (valid_l),
    .valid_r   (valid_r),
    .enable    (enable),
    .clr_flags (clr_flags),
    .axis      (axis.master),
    .level     (level),
    .overflow  (overflow),
    .sync_err  (sync_err)
  );

  always #5 AMSCK = ~AMSCK;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [32:0] q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [23:0] x);
    return {{8{x[23]}}, x};
  endfunction

  // Monitor: every accepted word is popped from the scoreboard and compared
  always @(negedge AMSCK) begin
    if (rst_n && axis.m_tvalid && axis.m_tready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h last %b, none required", axis.m_tdata, axis.m_tlast);
      end else begin
        logic [32:0] e;
        e = q.pop_front();
        check("word_data", axis.m_tdata, e[31:0]);
        check("word_last", 32'(axis.m_tlast), 32'(e[32]));
      end
    end
  end

  task automatic strobe(input logic l, input logic r, input logic [23:0] d);
    @(posedge AMSCK); #1;
    din = d; valid_l = l; valid_r = r;
    @(posedge AMSCK); #1;
    valid_l = 1'b0; valid_r = 1'b0;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input logic last);
    q.push_back({1'b0, sext(l)});
    q.push_back({last, sext(r)});
    strobe(1'b1, 1'b0, l);
    strobe(1'b0, 1'b1, r);
  endtask

  task automatic pulse_clr();
    @(posedge AMSCK); #1 clr_flags = 1'b1;
    @(posedge AMSCK); #1 clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; din = '0; valid_l = 1'b0; valid_r = 1'b0;
    enable = 1'b1; clr_flags = 1'b0; axis.m_tready = 1'b0;
    repeat (2) @(posedge AMSCK);
    #1 rst_n = 1'b1;
    q.delete();
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge AMSCK);
      if (q.size() == 0 && !axis.m_tvalid) break;
    end
    check({name, "_pending"}, 32'(q.size()), 32'd0);
    check({name, "_level"}, 32'(level), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      @(negedge AMSCK);
      if (axis.m_tvalid) break;
    end
    check({name, "_tvalid"}, 32'(axis.m_tvalid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; din = '0; valid_l = 1'b0; valid_r = 1'b0;
    enable = 1'b1; clr_flags = 1'b0; axis.m_tready = 1'b0;
    #2;
    check("rst_tvalid", 32'(axis.m_tvalid), 32'd0);
    check("rst_tdata", axis.m_tdata, 32'd0);
    check("rst_tlast", 32'(axis.m_tlast), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", {30'd0, overflow, sync_err}, 32'd0);

    // Test 1: basic frame
    do_reset();
    axis.m_tready = 1'b1;
    q.push_back({1'b0, 32'hFF80_0001});
    q.push_back({1'b0, 32'h0000_007F});
    strobe(1'b1, 1'b0, 24'h800001);
    strobe(1'b0, 1'b1, 24'h00007F);
    wait_drain("t1");

    // Test 2: packet boundary, tlast on right word of frames 3 and 7
    do_reset();
    axis.m_tready = 1'b1;
    for (int i = 0; i < 8; i++)
      send_frame(24'h100000 + 24'(i), 24'hF00000 + 24'(i), (i % 4) == 3);
    wait_drain("t2");

    // Test 3: overflow with backpressure, then drain of frames 0-3 only
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        q.push_back({1'b0, sext(24'h000A00 + 24'(i))});
        q.push_back({i == 3, sext(24'h800B00 + 24'(i))});
      end
      strobe(1'b1, 1'b0, 24'h000A00 + 24'(i));
      strobe(1'b0, 1'b1, 24'h800B00 + 24'(i));
    end
    repeat (4) @(negedge AMSCK);
    check("t3_level_full", 32'(level), 32'd4);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_tvalid", 32'(axis.m_tvalid), 32'd1);
    check("t3_tdata_hold0", axis.m_tdata, 32'h0000_0A00);
    repeat (5) @(negedge AMSCK);
    check("t3_tdata_hold1", axis.m_tdata, 32'h0000_0A00);
    check("t3_tlast_hold", 32'(axis.m_tlast), 32'd0);
    @(posedge AMSCK); #1 axis.m_tready = 1'b1;
    wait_drain("t3");
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check("t3_overflow_clr", 32'(overflow), 32'd0);

    // Test 4: sync errors
    do_reset();
    axis.m_tready = 1'b1;
    strobe(1'b1, 1'b0, 24'h111111);
    send_frame(24'h222222, 24'h333333, 1'b0);
    check("t4_sync_double_l", 32'(sync_err), 32'd1);
    pulse_clr();
    check("t4_sync_clr", 32'(sync_err), 32'd0);
    strobe(1'b0, 1'b1, 24'h444444);
    send_frame(24'h555555, 24'hA66666, 1'b0);
    check("t4_lead_r_noflag", 32'(sync_err), 32'd0);
    strobe(1'b1, 1'b0, 24'h777777);
    strobe(1'b1, 1'b1, 24'h888888);
    check("t4_sync_both", 32'(sync_err), 32'd1);
    strobe(1'b0, 1'b1, 24'h999999);
    send_frame(24'h0ABCDE, 24'hFEDCBA, 1'b0);
    wait_drain("t4");

    // Test 5a: enable dropped between left and right
    do_reset();
    axis.m_tready = 1'b1;
    strobe(1'b1, 1'b0, 24'h123456);
    @(posedge AMSCK); #1 enable = 1'b0;
    strobe(1'b0, 1'b1, 24'h654321);
    @(posedge AMSCK); #1 enable = 1'b1;
    strobe(1'b0, 1'b1, 24'h654322);
    wait_drain("t5_enable");

    // Test 5b: reset while the right word of a frame is presented
    strobe(1'b1, 1'b0, 24'h010101);
    send_frame(24'h020202, 24'h030303, 1'b0);
    check("t5_sync_pre", 32'(sync_err), 32'd1);
    wait_drain("t5_pre");
    axis.m_tready = 1'b0;
    send_frame(24'hC00001, 24'h3FFFFF, 1'b0);
    wait_valid("t5_stall");
    check("t5_left_word", axis.m_tdata, 32'hFFC0_0001);
    @(posedge AMSCK); #1 axis.m_tready = 1'b1;
    @(posedge AMSCK); #1 axis.m_tready = 1'b0;
    @(negedge AMSCK);
    check("t5_right_word", axis.m_tdata, 32'h003F_FFFF);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", 32'(axis.m_tvalid), 32'd0);
    check("t5_rst_tdata", axis.m_tdata, 32'd0);
    check("t5_rst_tlast", 32'(axis.m_tlast), 32'd0);
    check("t5_rst_level", 32'(level), 32'd0);
    check("t5_rst_flags", {30'd0, overflow, sync_err}, 32'd0);
    q.delete();
    repeat (2) @(posedge AMSCK);
    #1 rst_n = 1'b1;
    axis.m_tready = 1'b1;
    for (int i = 0; i < 4; i++)
      send_frame(24'h400000 + 24'(i), 24'h0000F0 + 24'(i), i == 3);
    wait_drain("t5_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
